// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with per-frame input snapshot,
// hex/BCD decode, leading-zero suppression and a blanking interval at the start of each slot.
module seg7_scan_driver #(
  parameter int NDIGITS        = 8,
  parameter int SCAN_DIV       = 100000,
  parameter int BLANK_CYC      = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     digit_en,
  input  logic                   hex_mode,
  input  logic                   lzs,
  output logic [NDIGITS-1:0]     an,
  output logic [6:0]             a2g,
  output logic                   dp_out,
  output logic                   frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NDIGITS - 1);
  localparam logic [NDIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {NDIGITS{1'b1}} : {NDIGITS{1'b0}};
  localparam logic [6:0]         SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic               DP_OFF  = SEG_ACTIVE_LOW;

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   loaded;
  logic                   frame_end;
  logic [4*NDIGITS-1:0]   data_sh;
  logic [NDIGITS-1:0]     dp_sh;
  logic [NDIGITS-1:0]     en_sh;
  logic                   hex_sh;
  logic                   lzs_sh;

  logic [NDIGITS-1:0]     suppress;
  logic                   zero_run;
  logic [3:0]             nib;
  logic [6:0]             seg_al;
  logic [NDIGITS-1:0]     an_next;
  logic [6:0]             a2g_next;
  logic                   dp_next;

  // Glyph table in active-low form; BCD mode shows a dash for A-F.
  function automatic logic [6:0] decode_al(input logic [3:0] n, input logic hex);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    if (!hex && n > 4'd9) g = 7'b0111111;
    return g;
  endfunction

  assign frame_end = (cnt == CNT_MAX) && (idx == IDX_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Snapshot on the first edge out of reset and at each frame end, so a frame never mixes inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loaded  <= 1'b0;
      data_sh <= '0;
      dp_sh   <= '0;
      en_sh   <= '0;
      hex_sh  <= 1'b0;
      lzs_sh  <= 1'b0;
    end else begin
      loaded <= 1'b1;
      if (!loaded || frame_end) begin
        data_sh <= data;
        dp_sh   <= dp;
        en_sh   <= digit_en;
        hex_sh  <= hex_mode;
        lzs_sh  <= lzs;
      end
    end
  end

  always_comb begin
    suppress = '0;
    zero_run = lzs_sh;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      if (data_sh[4*i +: 4] != 4'd0 || dp_sh[i]) zero_run = 1'b0;
      suppress[i] = zero_run;
    end
  end

  always_comb begin
    an_next  = AN_OFF;
    a2g_next = SEG_OFF;
    dp_next  = DP_OFF;
    nib      = data_sh[4*idx +: 4];
    seg_al   = decode_al(nib, hex_sh);
    // A suppressed digit keeps its anode so the scan duty cycle is unchanged.
    if (cnt >= BLANK_END && en_sh[idx]) begin
      an_next = AN_OFF ^ (NDIGITS'(1) << idx);
      if (!suppress[idx]) begin
        a2g_next = SEG_ACTIVE_LOW ? seg_al : ~seg_al;
        if (dp_sh[idx]) dp_next = ~DP_OFF;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= AN_OFF;
      a2g        <= SEG_OFF;
      dp_out     <= DP_OFF;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      a2g        <= a2g_next;
      dp_out     <= dp_next;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed plus randomized bench for seg7_scan_driver; expected outputs come from a
// position-based model of the scan (slot and cycle derived from elapsed clocks since reset).
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int S     = 4;
  localparam int B     = 1;
  localparam int FRAME = N * S;

  logic        clk;
  logic        reset;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        hex_mode;
  logic        lzs;
  logic [3:0]  an;
  logic [6:0]  a2g;
  logic        dp_out;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int k = 0;

  logic [15:0] s_data;
  logic [3:0]  s_dp;
  logic [3:0]  s_en;
  logic        s_hex;
  logic        s_lzs;

  seg7_scan_driver #(
    .NDIGITS(N), .SCAN_DIV(S), .BLANK_CYC(B), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .dp(dp), .digit_en(digit_en),
    .hex_mode(hex_mode), .lzs(lzs), .an(an), .a2g(a2g), .dp_out(dp_out),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Expected pins for the scan position p clocks after reset, using the frame's snapshot.
  function automatic void expect_out(input int p, output logic [3:0] e_an,
                                     output logic [6:0] e_seg, output logic e_dp);
    int slot;
    int c;
    bit sup;
    logic [3:0] n;
    slot  = (p / S) % N;
    c     = p % S;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (c < B || !s_en[slot]) return;
    e_an = ~(4'b0001 << slot);
    sup = s_lzs && (slot != 0);
    for (int j = N - 1; j >= slot; j--)
      if (s_data[4*j +: 4] != 4'd0 || s_dp[j]) sup = 1'b0;
    if (sup) return;
    n = s_data[4*slot +: 4];
    e_seg = (!s_hex && n > 4'd9) ? 7'b0111111 : glyph(n);
    e_dp  = ~s_dp[slot];
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_inactive(input string tag);
    check_output({tag, "_an"}, 32'(an), 32'hF);
    check_output({tag, "_a2g"}, 32'(a2g), 32'h7F);
    check_output({tag, "_dp"}, 32'(dp_out), 32'h1);
    check_output({tag, "_tick"}, 32'(frame_tick), 32'h0);
  endtask

  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] p,
                                input logic [3:0] en, input logic hx, input logic lz);
    data     = d;
    dp       = p;
    digit_en = en;
    hex_mode = hx;
    lzs      = lz;
  endtask

  task automatic run_cycles(input int n);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      k++;
      expect_out(k - 1, e_an, e_seg, e_dp);
      check_output("an", 32'(an), 32'(e_an));
      check_output("a2g", 32'(a2g), 32'(e_seg));
      check_output("dp_out", 32'(dp_out), 32'(e_dp));
      check_output("frame_tick", 32'(frame_tick), 32'(k % FRAME == 0));
      if (k == 1 || k % FRAME == 0) begin
        s_data = data;
        s_dp   = dp;
        s_en   = digit_en;
        s_hex  = hex_mode;
        s_lzs  = lzs;
      end
    end
  endtask

  initial begin
    logic [15:0] mask;
    s_data = '0; s_dp = '0; s_en = '0; s_hex = 1'b0; s_lzs = 1'b0;
    reset = 1'b0;
    apply_stimulus(16'h12AF, 4'b0000, 4'b1111, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1 check_inactive("reset");
    @(posedge clk);
    #1 check_inactive("reset_hold");
    #2 reset = 1'b0;
    k = 0;
    $display("[TB] hex scan 12AF");
    run_cycles(2 * FRAME);

    $display("[TB] BCD with leading-zero suppression 00A5");
    apply_stimulus(16'h00A5, 4'b0000, 4'b1111, 1'b0, 1'b1);
    run_cycles(2 * FRAME);

    $display("[TB] all zero with dp on digit 2");
    apply_stimulus(16'h0000, 4'b0100, 4'b1111, 1'b1, 1'b1);
    run_cycles(2 * FRAME);

    $display("[TB] mid-frame data change");
    apply_stimulus(16'h1234, 4'b0000, 4'b1111, 1'b1, 1'b0);
    run_cycles(FRAME - (k % FRAME));
    run_cycles(5);
    data = 16'h5678;
    run_cycles(2 * FRAME);

    $display("[TB] partial digit enable");
    apply_stimulus(16'h9C3E, 4'b1010, 4'b0101, 1'b1, 1'b0);
    run_cycles(2 * FRAME);

    $display("[TB] randomized inputs");
    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 3))
        0: mask = 16'hFFFF;
        1: mask = 16'h0FFF;
        2: mask = 16'h00FF;
        default: mask = 16'h000F;
      endcase
      apply_stimulus(16'($urandom) & mask, 4'($urandom) & mask[15:12] & 4'($urandom),
                     4'($urandom), 1'($urandom), 1'($urandom));
      run_cycles($urandom_range(3, 24));
    end

    $display("[TB] reset asserted mid-slot");
    run_cycles(FRAME + 6);
    #2 reset = 1'b1;
    #1 check_inactive("midreset");
    repeat (2) begin
      @(posedge clk);
      #1 check_inactive("midreset_hold");
    end
    apply_stimulus(16'h0B70, 4'b0001, 4'b1111, 1'b1, 1'b1);
    #2 reset = 1'b0;
    k = 0;
    run_cycles(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
